// File: rtl/crtc_char_shifter.sv
// ============================================================================
// Module   : crtc_char_shifter
// Purpose  : CRTC character-clock generator, VRAM/font fetch and pixel shifter.
//            Optional CURSOR_BLINK_EN enables the 8-frame cursor blink counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crtc_char_shifter #(
    parameter int PIX_PER_CHAR = 8
) (
    input  logic        CLOCK,
    input  logic        nRESET,
    input  logic        PIXEN,
    output logic        CCLKEN,
    input  logic [13:0] MA,
    input  logic [4:0]  RA,
    input  logic        DE,
    input  logic        CURSOR,
    input  logic        HSYNC,
    input  logic        VSYNC,
    output logic        VREQ,
    output logic [13:0] VADDR,
    input  logic        VACK,
    input  logic [7:0]  VDATA,
    input  logic [3:0]  CDATA,
    output logic [10:0] FADDR,
    input  logic [7:0]  FDATA,
    input  logic [3:0]  BORDER,
    output logic        PIX_ON,
    output logic [3:0]  PIX_COLOR,
    output logic        DE_O,
    output logic        HSYNC_O,
    output logic        VSYNC_O,
    output logic        UNDERRUN
);

    localparam logic [2:0] c_LAST = 3'(PIX_PER_CHAR - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_FONT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_pixcnt;
    logic        w_cclken;
    logic        w_slot_ok;
    logic        w_vreq;
    logic        w_blink_on;
    logic        w_cursor_inv;

    logic        r_s1_de;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_cursor;
    logic [2:0]  r_s1_ra;
    logic [13:0] r_vaddr;
    logic [10:0] r_faddr;
    logic [3:0]  r_colour;
    logic [3:0]  r_out_colour;
    logic [7:0]  r_pattern;
    logic [7:0]  r_shreg;
    logic        r_de_o;
    logic        r_hs_o;
    logic        r_vs_o;
    logic        r_underrun;

    wire w_unused = &{1'b0, RA[4:3]};

    assign w_cclken  = PIXEN && (r_pixcnt == c_LAST);
    assign w_slot_ok = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef CURSOR_BLINK_EN
    logic       r_vs_d;
    logic [3:0] r_blink;

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_vs_d  <= 1'b0;
            r_blink <= 4'd0;
        end else begin
            r_vs_d <= VSYNC;
            if (VSYNC && !r_vs_d)
                r_blink <= r_blink + 4'd1;
        end
    end

    assign w_blink_on = r_blink[3];
`else
    assign w_blink_on = 1'b1;
`endif

    assign w_cursor_inv = r_s1_cursor && r_s1_de && w_blink_on;

    // Fetch FSM: state register
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // A character boundary always restarts the fetch, aborting any in flight
    always_comb begin
        w_next = r_state;
        if (w_cclken) begin
            w_next = DE ? S_REQ : S_IDLE;
        end else begin
            case (r_state)
                S_REQ:   if (VACK) w_next = S_FONT;
                S_FONT:  w_next = S_CAPT;
                S_CAPT:  w_next = S_DONE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_vreq = (r_state == S_REQ);
    end

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_pixcnt     <= 3'd0;
            r_s1_de      <= 1'b0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_cursor  <= 1'b0;
            r_s1_ra      <= 3'd0;
            r_vaddr      <= 14'd0;
            r_faddr      <= 11'd0;
            r_colour     <= 4'd0;
            r_out_colour <= 4'd0;
            r_pattern    <= 8'd0;
            r_shreg      <= 8'd0;
            r_de_o       <= 1'b0;
            r_hs_o       <= 1'b0;
            r_vs_o       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (PIXEN)
                r_pixcnt <= (r_pixcnt == c_LAST) ? 3'd0 : r_pixcnt + 3'd1;

            if (w_cclken) begin
                r_s1_de      <= DE;
                r_s1_hs      <= HSYNC;
                r_s1_vs      <= VSYNC;
                r_s1_cursor  <= CURSOR;
                r_s1_ra      <= RA[2:0];
                r_vaddr      <= MA;
                r_de_o       <= r_s1_de;
                r_hs_o       <= r_s1_hs;
                r_vs_o       <= r_s1_vs;
                r_shreg      <= w_slot_ok ? r_pattern : 8'd0;
                r_out_colour <= r_colour;
                r_pattern    <= 8'd0;
                r_underrun   <= !w_slot_ok;
            end else begin
                if (PIXEN)
                    r_shreg <= {r_shreg[6:0], 1'b0};
                if ((r_state == S_REQ) && VACK) begin
                    r_colour <= CDATA;
                    r_faddr  <= {VDATA, r_s1_ra};
                end
                if (r_state == S_CAPT)
                    r_pattern <= FDATA ^ {8{w_cursor_inv}};
            end
        end
    end

    assign CCLKEN    = w_cclken;
    assign VREQ      = w_vreq;
    assign VADDR     = r_vaddr;
    assign FADDR     = r_faddr;
    assign PIX_ON    = r_shreg[7];
    assign PIX_COLOR = r_shreg[7] ? r_out_colour : BORDER;
    assign DE_O      = r_de_o;
    assign HSYNC_O   = r_hs_o;
    assign VSYNC_O   = r_vs_o;
    assign UNDERRUN  = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_crtc_char_shifter.sv
// ============================================================================
// Module   : tb_crtc_char_shifter
// Purpose  : Directed + randomized bench with a character-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crtc_char_shifter;

    logic        CLOCK = 1'b0;
    logic        nRESET = 1'b0;
    logic        PIXEN = 1'b0;
    logic        CCLKEN;
    logic [13:0] MA = '0;
    logic [4:0]  RA = '0;
    logic        DE = 1'b0, CURSOR = 1'b0, HSYNC = 1'b0, VSYNC = 1'b0;
    logic        VREQ;
    logic [13:0] VADDR;
    logic        VACK = 1'b0;
    logic [7:0]  VDATA = '0;
    logic [3:0]  CDATA = '0;
    logic [10:0] FADDR;
    logic [7:0]  FDATA = '0;
    logic [3:0]  BORDER = '0;
    logic        PIX_ON;
    logic [3:0]  PIX_COLOR;
    logic        DE_O, HSYNC_O, VSYNC_O, UNDERRUN;

    crtc_char_shifter #(.PIX_PER_CHAR(8)) dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .PIXEN(PIXEN), .CCLKEN(CCLKEN),
        .MA(MA), .RA(RA), .DE(DE), .CURSOR(CURSOR), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .VREQ(VREQ), .VADDR(VADDR), .VACK(VACK), .VDATA(VDATA), .CDATA(CDATA),
        .FADDR(FADDR), .FDATA(FDATA), .BORDER(BORDER), .PIX_ON(PIX_ON),
        .PIX_COLOR(PIX_COLOR), .DE_O(DE_O), .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O),
        .UNDERRUN(UNDERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [7:0] font(input logic [10:0] a);
        if (a == 11'h20A)
            return 8'h3C;
        return 8'(a * 11'd29) ^ {a[10:8], a[4:0]};
    endfunction

    // Font ROM: one CLOCK of read latency
    always @(posedge CLOCK) FDATA <= font(FADDR);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus control
    logic        rnd = 1'b0;
    logic [13:0] s_ma = '0;
    logic [2:0]  s_ra = '0;
    logic        s_de = 1'b0, s_cur = 1'b0, s_hs = 1'b0;
    logic [7:0]  s_vdata = '0;
    logic [3:0]  s_cdata = '0;
    int          s_lat = 1;

    // model: character being fetched
    int          cyc = 0;
    int          pcnt = 0;
    logic [13:0] m_ma = '0;
    logic [2:0]  m_ra = '0;
    logic        m_de = 1'b0, m_cur = 1'b0, m_hs = 1'b0, m_vs = 1'b0;
    logic        m_pend = 1'b0, m_acked = 1'b0;
    int          m_ack_cyc = 0;
    logic [7:0]  m_code = '0;
    logic [3:0]  m_col = '0;
    // model: character on screen
    logic [7:0]  d_pat = '0;
    logic [3:0]  d_col = '0;
    logic        d_de = 1'b0, d_hs = 1'b0, d_vs = 1'b0;
    int          d_bit = 8;
    logic        exp_under = 1'b0;
    // VRAM responder
    int          v_wait = 0, v_lat = 1;
    logic        v_done = 1'b0;

    task automatic model_reset();
        pcnt = 0; m_de = 0; m_cur = 0; m_hs = 0; m_vs = 0; m_pend = 0; m_acked = 0;
        d_pat = 0; d_col = 0; d_de = 0; d_hs = 0; d_vs = 0; d_bit = 8;
        exp_under = 0; v_wait = 0; v_lat = 1; v_done = 0;
    endtask

    task automatic cycle();
        logic exp_cclk, fin_under, fresh, exp_pix;
        fresh = 1'b0;
        @(negedge CLOCK);
        if (rnd) begin
            PIXEN  = ($urandom_range(0, 3) != 0);
            MA     = 14'($urandom);
            RA     = 5'($urandom);
            DE     = ($urandom_range(0, 3) != 0);
            CURSOR = ($urandom_range(0, 3) == 0);
            HSYNC  = 1'($urandom);
            VSYNC  = 1'($urandom);
            BORDER = 4'($urandom);
        end else begin
            PIXEN = 1'b1; MA = s_ma; RA = {2'b00, s_ra}; DE = s_de;
            CURSOR = s_cur; HSYNC = s_hs; VSYNC = 1'b0; BORDER = 4'hA;
        end
        VACK = 1'b0;
        if (VREQ && !v_done) begin
            v_wait++;
            if (v_wait >= v_lat) begin
                VACK   = 1'b1;
                VDATA  = rnd ? 8'($urandom) : s_vdata;
                CDATA  = rnd ? 4'($urandom) : s_cdata;
                v_done = 1'b1;
            end
        end
        #1;
        exp_cclk = PIXEN && (pcnt == 7);
        check_val("cclken", CCLKEN, exp_cclk);
        check_val("vreq", VREQ, m_pend);
        if (m_pend) check_val("vaddr", VADDR, m_ma);
        @(posedge CLOCK);
        cyc++;
        if (exp_cclk) begin
            // fetch result is usable only if the font byte landed before this boundary
            fin_under = m_de && !(m_acked && (m_ack_cyc + 2 < cyc));
            exp_under = fin_under;
            d_pat = (!m_de || fin_under) ? 8'h00 : (font({m_code, m_ra}) ^ (m_cur ? 8'hFF : 8'h00));
            d_col = m_col; d_de = m_de; d_hs = m_hs; d_vs = m_vs; d_bit = 0;
            m_ma = MA; m_ra = RA[2:0]; m_de = DE; m_cur = CURSOR; m_hs = HSYNC; m_vs = VSYNC;
            m_pend = DE; m_acked = 1'b0;
            v_wait = 0; v_done = 1'b0;
            v_lat = rnd ? $urandom_range(1, 8) : s_lat;
        end else begin
            exp_under = 1'b0;
            if (m_pend && VACK) begin
                m_acked = 1'b1; m_ack_cyc = cyc; m_code = VDATA; m_col = CDATA;
                m_pend = 1'b0; fresh = 1'b1;
            end
            if (PIXEN) d_bit++;
        end
        if (PIXEN) pcnt = (pcnt + 1) % 8;
        #1;
        exp_pix = (d_bit < 8) ? d_pat[7 - d_bit] : 1'b0;
        check_val("pix_on", PIX_ON, exp_pix);
        check_val("pix_color", PIX_COLOR, exp_pix ? d_col : BORDER);
        check_val("de_o", DE_O, d_de);
        check_val("hsync_o", HSYNC_O, d_hs);
        check_val("vsync_o", VSYNC_O, d_vs);
        check_val("underrun", UNDERRUN, exp_under);
        if (fresh) check_val("faddr", FADDR, {m_code, m_ra});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_vreq"}, VREQ, 1'b0);
        check_val({tag, "_vaddr"}, VADDR, 14'd0);
        check_val({tag, "_faddr"}, FADDR, 11'd0);
        check_val({tag, "_pix_on"}, PIX_ON, 1'b0);
        check_val({tag, "_syncs"}, {DE_O, HSYNC_O, VSYNC_O, UNDERRUN}, 4'd0);
        check_val({tag, "_cclken"}, CCLKEN, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_outputs("rst");
        check_val("rst_pix_color", PIX_COLOR, 4'd0);
        @(negedge CLOCK);
        nRESET = 1'b1;
        model_reset();

        // constant PIXEN, display disabled
        run(16);
        // plain character fetch
        s_ma = 14'h0123; s_ra = 3'd2; s_de = 1'b1; s_vdata = 8'h41; s_cdata = 4'd5; s_lat = 1;
        run(24);
        // cursor inversion
        s_cur = 1'b1;
        run(16);
        s_cur = 1'b0;
        // display disabled at sample
        s_de = 1'b0;
        run(16);
        // VACK withheld past the next boundary
        s_de = 1'b1; s_lat = 20;
        run(8);
        s_lat = 1; s_ma = 14'h0456;
        run(24);
        // HSYNC for three characters
        s_hs = 1'b1;
        run(24);
        s_hs = 1'b0;
        run(16);

        rnd = 1'b1;
        run(1500);
        for (int i = 0; i < 200 && !m_pend; i++) cycle();
        check_val("vreq_pre_rst", VREQ, 1'b1);
        @(negedge CLOCK);
        #2 nRESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        VACK = 1'b0; PIXEN = 1'b0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        nRESET = 1'b1;
        model_reset();
        run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
